// File: rtl/mp85_bus_pkg.sv
// Shared MP85 bus definitions: machine-cycle codes, T-state encoding and
// per-type bus status / strobe classification helpers.
package mp85_bus_pkg;

  typedef enum logic [2:0] {
    MC_OF4  = 3'd0,
    MC_OF6  = 3'd1,
    MC_MR   = 3'd2,
    MC_MW   = 3'd3,
    MC_IOR  = 3'd4,
    MC_IOW  = 3'd5,
    MC_INA  = 3'd6,
    MC_HALT = 3'd7
  } mc_type_e;

  typedef enum logic [3:0] {
    TS_IDLE  = 4'd0,
    TS_T1    = 4'd1,
    TS_T2    = 4'd2,
    TS_TW    = 4'd3,
    TS_T3    = 4'd4,
    TS_T4    = 4'd5,
    TS_T5    = 4'd6,
    TS_T6    = 4'd7,
    TS_THALT = 4'd8,
    TS_THOLD = 4'd9
  } t_state_e;

  typedef struct packed {
    logic io_m;
    logic s1;
    logic s0;
  } bus_status_t;

  localparam bus_status_t ST_NONE = '{io_m: 1'b0, s1: 1'b0, s0: 1'b0};

  function automatic bus_status_t status_of(input mc_type_e t);
    bus_status_t st;
    case (t)
      MC_OF4, MC_OF6: st = '{io_m: 1'b0, s1: 1'b1, s0: 1'b1};
      MC_MR:          st = '{io_m: 1'b0, s1: 1'b1, s0: 1'b0};
      MC_MW:          st = '{io_m: 1'b0, s1: 1'b0, s0: 1'b1};
      MC_IOR:         st = '{io_m: 1'b1, s1: 1'b1, s0: 1'b0};
      MC_IOW:         st = '{io_m: 1'b1, s1: 1'b0, s0: 1'b1};
      MC_INA:         st = '{io_m: 1'b1, s1: 1'b1, s0: 1'b1};
      default:        st = ST_NONE;
    endcase
    return st;
  endfunction

  function automatic logic is_read(input mc_type_e t);
    return (t == MC_OF4) || (t == MC_OF6) || (t == MC_MR) || (t == MC_IOR);
  endfunction

  function automatic logic is_write(input mc_type_e t);
    return (t == MC_MW) || (t == MC_IOW);
  endfunction

  function automatic logic is_inta(input mc_type_e t);
    return t == MC_INA;
  endfunction

  function automatic logic is_fetch(input mc_type_e t);
    return (t == MC_OF4) || (t == MC_OF6);
  endfunction

  // INTA returns an opcode on the data bus, so it captures like a read.
  function automatic logic captures_data(input mc_type_e t);
    return is_read(t) || is_inta(t);
  endfunction

endpackage

// File: rtl/mp85_wait_timer.sv
// Wait-state counter: clear / load-one / saturating increment, plus timeout compare.
// Latency: count updates on the next clk edge; timeout is combinational from the count.
// Backpressure: none; WAIT_TIMEOUT = 0 disables the timeout flag entirely.
module mp85_wait_timer #(
  parameter int WCNT_W       = 8,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic set_one,
  input  logic inc,
  output logic timeout
);

  localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_TIMEOUT);
  localparam logic [WCNT_W-1:0] SAT   = '1;
  localparam logic [WCNT_W-1:0] ONE   = WCNT_W'(1);

  logic [WCNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (set_one) begin
      cnt <= ONE;
    end else if (inc && (cnt != SAT)) begin
      cnt <= cnt + ONE;
    end
  end

  assign timeout = (WAIT_TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/mp85_mcycle_sequencer.sv
// MP85 machine-cycle / T-state sequencer; owns all bus strobe timing (HOLD_EN enables DMA hold).
// Latency: mc_ack one cycle after mc_req in IDLE; back-to-back cycles with zero idle states.
// Backpressure: ready stretches T2 into TW states; mc_req is held by the decoder until mc_ack.
module mp85_mcycle_sequencer
  import mp85_bus_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 0,
  parameter int WCNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mc_req,
  input  logic [2:0] mc_type,
  input  logic       ready,
  input  logic       wake,
  input  logic       hold,
  output logic       mc_ack,
  output logic       mc_done,
  output logic       mc_err,
  output logic       dlatch,
  output logic       ale,
  output logic       rd_n,
  output logic       wr_n,
  output logic       inta_n,
  output logic       io_m,
  output logic       s1,
  output logic       s0,
  output t_state_e   t_state,
  output logic       hlda
);

  t_state_e    state_q, state_d;
  mc_type_e    typ_q;
  logic        load_typ;
  logic        wt_set, wt_inc, wt_timeout;
  logic        hold_take;
  logic        strobe;
  bus_status_t st;

`ifdef HOLD_EN
  assign hold_take = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign hold_take   = 1'b0;
`endif

  mp85_wait_timer #(
    .WCNT_W      (WCNT_W),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (load_typ),
    .set_one(wt_set),
    .inc    (wt_inc),
    .timeout(wt_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TS_IDLE;
      typ_q   <= MC_OF4;
    end else begin
      state_q <= state_d;
      if (load_typ) begin
        typ_q <= mc_type_e'(mc_type);
      end
    end
  end

  // mc_done marks the end-of-cycle edge; hold outranks a waiting request there.
  always_comb begin
    state_d  = state_q;
    load_typ = 1'b0;
    wt_set   = 1'b0;
    wt_inc   = 1'b0;
    case (state_q)
      TS_IDLE: begin
        if (hold_take) begin
          state_d = TS_THOLD;
        end else if (mc_req) begin
          state_d  = TS_T1;
          load_typ = 1'b1;
        end
      end
      TS_T1:    state_d = (typ_q == MC_HALT) ? TS_THALT : TS_T2;
      TS_T2: begin
        if (ready) begin
          state_d = TS_T3;
        end else begin
          state_d = TS_TW;
          wt_set  = 1'b1;
        end
      end
      TS_TW: begin
        if (ready) begin
          state_d = TS_T3;
        end else begin
          wt_inc = 1'b1;
        end
      end
      TS_T3:    if (is_fetch(typ_q)) state_d = TS_T4;
      TS_T4:    if (typ_q == MC_OF6) state_d = TS_T5;
      TS_T5:    state_d = TS_T6;
      TS_T6:    state_d = TS_T6;
      TS_THALT: state_d = TS_THALT;
      TS_THOLD: begin
        if (!hold_take) begin
          if (mc_req) begin
            state_d  = TS_T1;
            load_typ = 1'b1;
          end else begin
            state_d = TS_IDLE;
          end
        end
      end
      default:  state_d = TS_IDLE;
    endcase

    if (mc_done) begin
      wt_inc = 1'b0;
      if (hold_take) begin
        state_d = TS_THOLD;
      end else if (mc_req) begin
        state_d  = TS_T1;
        load_typ = 1'b1;
      end else begin
        state_d = TS_IDLE;
      end
    end
  end

  always_comb begin
    st      = ST_NONE;
    strobe  = 1'b0;
    ale     = 1'b0;
    mc_ack  = 1'b0;
    mc_done = 1'b0;
    mc_err  = 1'b0;
    dlatch  = 1'b0;
    if (state_q inside {TS_T1, TS_T2, TS_TW, TS_T3, TS_T4, TS_T5, TS_T6}) begin
      st = status_of(typ_q);
    end
    if (state_q inside {TS_T2, TS_TW, TS_T3}) begin
      strobe = 1'b1;
    end
    case (state_q)
      TS_T1: begin
        ale    = 1'b1;
        mc_ack = 1'b1;
      end
      TS_TW: begin
        if (wt_timeout && !ready) begin
          mc_done = 1'b1;
          mc_err  = 1'b1;
        end
      end
      TS_T3: begin
        dlatch  = captures_data(typ_q);
        mc_done = !is_fetch(typ_q);
      end
      TS_T4:    mc_done = (typ_q == MC_OF4);
      TS_T6:    mc_done = 1'b1;
      TS_THALT: mc_done = wake;
      default: ;
    endcase
    rd_n   = !(strobe && is_read(typ_q));
    wr_n   = !(strobe && is_write(typ_q));
    inta_n = !(strobe && is_inta(typ_q));
  end

  assign io_m    = st.io_m;
  assign s1      = st.s1;
  assign s0      = st.s0;
  assign t_state = state_q;

`ifdef HOLD_EN
  assign hlda = (state_q == TS_THOLD);
`else
  assign hlda = 1'b0;
`endif

endmodule

// File: tb/tb_mp85_mcycle_sequencer.sv
// Scenario bench for the MP85 sequencer: default instance plus a WAIT_TIMEOUT=2 instance.
module tb_mp85_mcycle_sequencer;
  import mp85_bus_pkg::*;

  typedef struct packed {
    logic       err;
    logic [2:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst, mc_req, ready, wake, hold;
  logic [2:0] mc_type;
  logic mc_ack, mc_done, mc_err, dlatch, ale, rd_n, wr_n, inta_n, io_m, s1, s0, hlda;
  t_state_e t_state;

  logic req2, ready2, wake2;
  logic [2:0] type2;
  logic mc_ack_b, mc_done_b, mc_err_b, dlatch_b, ale_b, rd_n_b, wr_n_b, inta_n_b;
  logic io_m_b, s1_b, s0_b, hlda_b;
  t_state_e t_state_b;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mp85_mcycle_sequencer dut (
    .clk(clk), .rst(rst), .mc_req(mc_req), .mc_type(mc_type), .ready(ready),
    .wake(wake), .hold(hold), .mc_ack(mc_ack), .mc_done(mc_done), .mc_err(mc_err),
    .dlatch(dlatch), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .inta_n(inta_n),
    .io_m(io_m), .s1(s1), .s0(s0), .t_state(t_state), .hlda(hlda)
  );

  mp85_mcycle_sequencer #(.WAIT_TIMEOUT(2), .WCNT_W(8)) dut_to (
    .clk(clk), .rst(rst), .mc_req(req2), .mc_type(type2), .ready(ready2),
    .wake(wake2), .hold(hold), .mc_ack(mc_ack_b), .mc_done(mc_done_b), .mc_err(mc_err_b),
    .dlatch(dlatch_b), .ale(ale_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .inta_n(inta_n_b),
    .io_m(io_m_b), .s1(s1_b), .s0(s0_b), .t_state(t_state_b), .hlda(hlda_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mc_req = 1'b0; mc_type = 3'd0; ready = 1'b1; wake = 1'b0; hold = 1'b0;
    req2 = 1'b0; type2 = 3'd0; ready2 = 1'b1; wake2 = 1'b0;
    tick(); tick();
    vectors++;
    if (t_state !== TS_IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d want %0d", t_state, TS_IDLE);
    end
    vectors++;
    if ({mc_ack, mc_done, mc_err, dlatch, ale, io_m, s1, s0, hlda} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want 000000000",
               {mc_ack, mc_done, mc_err, dlatch, ale, io_m, s1, s0, hlda});
    end
    vectors++;
    if ({rd_n, wr_n, inta_n} !== 3'b111) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 111", {rd_n, wr_n, inta_n});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_of4();
    exp_t e;
    mc_req = 1'b1; mc_type = MC_OF4; ready = 1'b1;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b011});
    tick();  // T1
    vectors++;
    if ({t_state, ale, mc_ack, io_m, s1, s0} !== {TS_T1, 5'b11011}) begin
      miscompares++;
      $display("FAIL of4_t1: got state %0d ale/ack/st %b want state 1 11011",
               t_state, {ale, mc_ack, io_m, s1, s0});
    end
    mc_req = 1'b0;
    tick();  // T2
    vectors++;
    if ({rd_n, dlatch, mc_done} !== 3'b000) begin
      miscompares++; $display("FAIL of4_t2: got rd_n/dlatch/done %b want 000", {rd_n, dlatch, mc_done});
    end
    tick();  // T3
    vectors++;
    if ({rd_n, dlatch, mc_done} !== 3'b010) begin
      miscompares++; $display("FAIL of4_t3: got rd_n/dlatch/done %b want 010", {rd_n, dlatch, mc_done});
    end
    tick();  // T4
    vectors++;
    if (mc_done !== 1'b1 || rd_n !== 1'b1 || sb.size() == 0) begin
      miscompares++;
      $display("FAIL of4_done: got done=%b rd_n=%b queued=%0d want done=1 rd_n=1", mc_done, rd_n, sb.size());
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({mc_err, io_m, s1, s0} !== e) begin
        miscompares++; $display("FAIL of4_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
      end
    end
    tick();
    vectors++;
    if (t_state !== TS_IDLE) begin
      miscompares++; $display("FAIL of4_idle: got %0d want %0d", t_state, TS_IDLE);
    end
  endtask

  task automatic test_mw_wait();
    exp_t e;
    int tw = 0, wl = 0, dl = 0;
    bit done = 1'b0;
    mc_req = 1'b1; mc_type = MC_MW; ready = 1'b0;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b001});
    tick();  // T1
    vectors++;
    if (mc_ack !== 1'b1) begin
      miscompares++; $display("FAIL mw_ack: got %b want 1", mc_ack);
    end
    mc_req = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (wr_n === 1'b0) wl++;
      if (dlatch === 1'b1) dl++;
      if (t_state == TS_TW) begin
        tw++;
        if (tw == 3) ready = 1'b1;
      end
      if (mc_done === 1'b1) begin
        done = 1'b1;
        vectors++;
        if (t_state !== TS_T3 || sb.size() == 0) begin
          miscompares++; $display("FAIL mw_done_state: got %0d queued=%0d want %0d", t_state, sb.size(), TS_T3);
        end else begin
          e = sb.pop_front();
          vectors++;
          if ({mc_err, io_m, s1, s0} !== e) begin
            miscompares++; $display("FAIL mw_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
          end
        end
      end
    end
    vectors++;
    if (!done) begin
      miscompares++; $display("FAIL mw_timeout: mc_done not seen in 20 cycles");
    end
    vectors++;
    if ({tw, wl, dl} !== {32'd3, 32'd5, 32'd0}) begin
      miscompares++; $display("FAIL mw_counts: got tw=%0d wr_low=%0d dlatch=%0d want 3 5 0", tw, wl, dl);
    end
    tick();
    vectors++;
    if ({wr_n, t_state} !== {1'b1, TS_IDLE}) begin
      miscompares++; $display("FAIL mw_release: got wr_n=%b state=%0d want 1 0", wr_n, t_state);
    end
  endtask

  task automatic test_timeout();
    req2 = 1'b1; type2 = MC_IOR; ready2 = 1'b0;
    tick();  // T1
    vectors++;
    if ({mc_ack_b, t_state_b} !== {1'b1, TS_T1}) begin
      miscompares++; $display("FAIL to_t1: got ack=%b state=%0d want 1 1", mc_ack_b, t_state_b);
    end
    req2 = 1'b0;
    tick();  // T2
    tick();  // TW #1
    vectors++;
    if ({t_state_b, mc_done_b, mc_err_b, rd_n_b} !== {TS_TW, 3'b000}) begin
      miscompares++;
      $display("FAIL to_tw1: got state=%0d done/err/rd_n=%b want 3 000", t_state_b, {mc_done_b, mc_err_b, rd_n_b});
    end
    tick();  // TW #2
    vectors++;
    if ({t_state_b, mc_done_b, mc_err_b, rd_n_b} !== {TS_TW, 3'b110}) begin
      miscompares++;
      $display("FAIL to_tw2: got state=%0d done/err/rd_n=%b want 3 110", t_state_b, {mc_done_b, mc_err_b, rd_n_b});
    end
    vectors++;
    if ({ale_b, wr_n_b, inta_n_b, io_m_b, s1_b, s0_b, hlda_b, dlatch_b} !== 8'b01111000) begin
      miscompares++;
      $display("FAIL to_bus: got %b want 01111000",
               {ale_b, wr_n_b, inta_n_b, io_m_b, s1_b, s0_b, hlda_b, dlatch_b});
    end
    tick();
    vectors++;
    if ({rd_n_b, mc_done_b, t_state_b} !== {2'b10, TS_IDLE}) begin
      miscompares++; $display("FAIL to_release: got rd_n=%b done=%b state=%0d want 1 0 0", rd_n_b, mc_done_b, t_state_b);
    end
    ready2 = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    mc_req = 1'b1; mc_type = MC_MR; ready = 1'b1;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b010});
    tick();  // MR T1, request for OF6 presented right away
    mc_type = MC_OF6;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b011});
    tick();  // MR T2
    vectors++;
    if ({mc_ack, rd_n} !== 2'b00) begin
      miscompares++; $display("FAIL b2b_t2: got ack/rd_n %b want 00", {mc_ack, rd_n});
    end
    tick();  // MR T3
    vectors++;
    if (mc_done !== 1'b1 || dlatch !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL b2b_mr_done: got done=%b dlatch=%b want 1 1", mc_done, dlatch);
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({mc_err, io_m, s1, s0} !== e) begin
        miscompares++; $display("FAIL b2b_mr_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
      end
    end
    tick();  // OF6 T1 directly
    vectors++;
    if ({t_state, mc_ack, io_m, s1, s0} !== {TS_T1, 4'b1011}) begin
      miscompares++; $display("FAIL b2b_of6_t1: got state=%0d ack/st=%b want 1 1011", t_state, {mc_ack, io_m, s1, s0});
    end
    mc_req = 1'b0;
    tick(); tick(); tick(); tick();  // T2 T3 T4 T5
    vectors++;
    if ({t_state, mc_done, rd_n} !== {TS_T5, 2'b01}) begin
      miscompares++; $display("FAIL b2b_t5: got state=%0d done=%b rd_n=%b want 6 0 1", t_state, mc_done, rd_n);
    end
    tick();  // T6
    vectors++;
    if (t_state !== TS_T6 || mc_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL b2b_of6_done: got state=%0d done=%b want 7 1", t_state, mc_done);
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({mc_err, io_m, s1, s0} !== e) begin
        miscompares++; $display("FAIL b2b_of6_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
      end
    end
    tick();
    vectors++;
    if (t_state !== TS_IDLE) begin
      miscompares++; $display("FAIL b2b_idle: got %0d want 0", t_state);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int halt_cyc = 0, dones = 0;
    mc_req = 1'b1; mc_type = MC_HALT;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b000});
    tick();  // T1
    vectors++;
    if ({mc_ack, io_m, s1, s0} !== 4'b1000) begin
      miscompares++; $display("FAIL halt_t1: got ack/st %b want 1000", {mc_ack, io_m, s1, s0});
    end
    mc_req = 1'b0;
    tick();  // first THALT
    for (int i = 0; i < 10; i++) begin
      if (t_state == TS_THALT && {io_m, s1, s0, rd_n, wr_n, inta_n} == 6'b000111) halt_cyc++;
      if (i == 9) begin
        wake = 1'b1;
        #1;
      end
      if (mc_done === 1'b1) begin
        dones++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          vectors++;
          if ({mc_err, io_m, s1, s0} !== e) begin
            miscompares++; $display("FAIL halt_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
          end
        end
      end
      if (i < 9) tick();
    end
    vectors++;
    if ({halt_cyc, dones} !== {32'd10, 32'd1}) begin
      miscompares++; $display("FAIL halt_counts: got thalt=%0d dones=%0d want 10 1", halt_cyc, dones);
    end
    tick();
    wake = 1'b0;
    vectors++;
    if (t_state !== TS_IDLE) begin
      miscompares++; $display("FAIL halt_exit: got %0d want 0", t_state);
    end
  endtask

  task automatic test_async_reset();
    mc_req = 1'b1; mc_type = MC_OF4; ready = 1'b1;
    tick();  // T1
    mc_req = 1'b0;
    tick();  // T2
    vectors++;
    if (rd_n !== 1'b0) begin
      miscompares++; $display("FAIL arst_pre: got rd_n=%b want 0", rd_n);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({rd_n, t_state} !== {1'b1, TS_IDLE}) begin
      miscompares++; $display("FAIL arst_abort: got rd_n=%b state=%0d want 1 0", rd_n, t_state);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    vectors++;
    if ({t_state, mc_done} !== {TS_IDLE, 1'b0}) begin
      miscompares++; $display("FAIL arst_after: got state=%0d done=%b want 0 0", t_state, mc_done);
    end
  endtask

`ifdef HOLD_EN
  task automatic test_hold();
    exp_t e;
    mc_req = 1'b1; mc_type = MC_MR; ready = 1'b1;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b010});
    tick();  // T1
    mc_req = 1'b0;
    tick();  // T2
    hold = 1'b1;
    tick();  // T3: cycle still completes
    vectors++;
    if (mc_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL hold_done: got done=%b state=%0d want 1 4", mc_done, t_state);
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({mc_err, io_m, s1, s0} !== e) begin
        miscompares++; $display("FAIL hold_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
      end
    end
    tick();  // THOLD
    vectors++;
    if ({t_state, hlda, ale, io_m, s1, s0, rd_n} !== {TS_THOLD, 6'b100001}) begin
      miscompares++;
      $display("FAIL hold_thold: got state=%0d bits=%b want 9 100001", t_state, {hlda, ale, io_m, s1, s0, rd_n});
    end
    tick(); tick();
    hold = 1'b0; mc_req = 1'b1; mc_type = MC_OF4;
    sb.push_back(exp_t'{err: 1'b0, st: 3'b011});
    tick();  // resume with T1
    vectors++;
    if ({t_state, hlda, mc_ack} !== {TS_T1, 2'b01}) begin
      miscompares++; $display("FAIL hold_resume: got state=%0d hlda=%b ack=%b want 1 0 1", t_state, hlda, mc_ack);
    end
    mc_req = 1'b0;
    tick(); tick(); tick();  // T2 T3 T4
    vectors++;
    if (mc_done !== 1'b1 || sb.size() == 0) begin
      miscompares++; $display("FAIL hold_of4_done: got done=%b want 1", mc_done);
    end else begin
      e = sb.pop_front();
      vectors++;
      if ({mc_err, io_m, s1, s0} !== e) begin
        miscompares++; $display("FAIL hold_of4_result: got %b want %b", {mc_err, io_m, s1, s0}, e);
      end
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_of4();
    test_mw_wait();
    test_timeout();
    test_back_to_back();
    test_halt();
    test_async_reset();
`ifdef HOLD_EN
    test_hold();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
